serial_add_sub: RTL and testbench
=================================

// Module: serial_add_sub
// PURPOSE
//   Bit-serial add/subtract engine in front of the single-bit Full_Adder cell.
//   Latches two WIDTH-bit operands on start_i and feeds one bit pair per clock,
//   LSB first, through one Full_Adder instance. Collects sum bits into a result
//   register and reports carry/borrow. Trades WIDTH+1 cycles of latency for one adder cell.
// PARAMETERS
//   WIDTH  4  operand/result width in bits (>=2)
// PORTS
//   clk_i       in   1      single clock, rising edge
//   rst_n_i     in   1      asynchronous, active-low reset
//   start_i     in   1      request; accepted only in IDLE or DONE
//   sub_i       in   1      0 = a+b, 1 = a-b; sampled with start_i
//   a_i         in   WIDTH  operand A; sampled with start_i
//   b_i         in   WIDTH  operand B; sampled with start_i
//   busy_o      out  1      high while in SHIFT
//   done_o      out  1      high for the single DONE cycle
//   result_o    out  WIDTH  sum/difference, valid from DONE until next accept
//   carry_o     out  1      final carry-out (sub: 1 = no borrow)
//   overflow_o  out  1      signed overflow (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (any time, including mid-SHIFT): state IDLE, busy_o=0, done_o=0,
//     result_o=0, carry_o=0, overflow_o=0, counter=0; operation in flight aborted.
//   - FSM: IDLE -start_i-> SHIFT; SHIFT -(count==WIDTH-1)-> DONE;
//     DONE -start_i-> SHIFT, else -> IDLE. DONE lasts exactly one cycle.
//   - Accept edge: a_sh<=a_i, b_sh<=b_i^{WIDTH{sub_i}}, c_reg<=sub_i,
//     count<=0, sub latched; result_o, carry_o, overflow_o cleared.
//   - Each SHIFT edge: FA inputs a_sh[0], b_sh[0], c_reg; a_sh/b_sh shift right;
//     sum bit shifts into result MSB (result>>1 | sum<<(WIDTH-1)); c_reg<=carry;
//     count increments. On last bit, c_reg before update is kept as c_msb_in.
//   - Latency: start_i high at edge N -> done_o high in the cycle after edge N+WIDTH.
//   - start_i during SHIFT ignored (no queueing); operands may change freely then.
//   - Width rule: result modulo 2^WIDTH; carry_o = carry out of bit WIDTH-1.
//   - result_o/carry_o/overflow_o hold after DONE through IDLE until next accept.
// CONFIGURATION
//   SERIAL_ADD_SUB_OVF_EN defined: overflow_o = c_msb_in ^ carry_o, registered
//     with the last SHIFT edge, valid with done_o.
//   Not defined: overflow_o tied to 0, c_msb_in register not built.
// STRUCTURE
//   Shared package/include add_sub_pkg: FSM state encodings (ST_IDLE=2'd0,
//   ST_SHIFT=2'd1, ST_DONE=2'd2), OP_ADD=1'b0, OP_SUB=1'b1.
//   One sub-module: existing Full_Adder (a_i, b_i, c_in, sum_o, carry_o),
//   instantiated once; counter width $clog2(WIDTH).
// TESTING
//   - add 3+5 (WIDTH=4) -> result_o=4'h8, carry_o=0, overflow_o=1 (OVF_EN), done at start+5.
//   - sub 7-2 -> result_o=4'h5, carry_o=1, overflow_o=0.
//   - sub 2-7 -> result_o=4'hB, carry_o=0 (borrow), overflow_o=0.
//   - add F+1 -> result_o=4'h0, carry_o=1, overflow_o=0; busy_o high exactly 4 cycles.
//   - start_i pulsed with 1+1 during SHIFT of 3+5 -> ignored, result 8; start in DONE -> back-to-back.
//   - rst_n_i low for 1 cycle mid-SHIFT -> all outputs 0 immediately, IDLE, no done_o.

Source files
------------

// File: rtl/add_sub_pkg.sv
// Shared definitions for the bit-serial add/subtract engine: FSM state encodings
// and operation codes.
package add_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_if.sv
// Request/result bundle of serial_add_sub; the requester owns start/sub/operands,
// the engine owns status and result.
interface serial_add_sub_if #(
    parameter int WIDTH = 4
) ();
    // start_i is a one-cycle request; it is taken only when busy_o is low
    // (IDLE or DONE). done_o pulses for exactly one cycle per accepted request.
    logic             start_i;
    logic             sub_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             carry_o;
    logic             overflow_o;

    modport master (
        output start_i, sub_i, a_i, b_i,
        input  busy_o, done_o, result_o, carry_o, overflow_o
    );

    modport slave (
        input  start_i, sub_i, a_i, b_i,
        output busy_o, done_o, result_o, carry_o, overflow_o
    );
endinterface

// File: rtl/Full_Adder.sv
// Single-bit full adder cell shared by the serial datapath.
module Full_Adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_in,
    output logic sum_o,
    output logic carry_o
);
    assign sum_o   = a_i ^ b_i ^ c_in;
    assign carry_o = (a_i & b_i) | (c_in & (a_i ^ b_i));
endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract: one Full_Adder processes one bit pair per clock, LSB first.
// Optional signed-overflow flag built when SERIAL_ADD_SUB_OVF_EN is defined.
module serial_add_sub
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    serial_add_sub_if.slave bus,
    output state_t          state_dbg_o
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, result;
    logic [CW-1:0]    count;
    logic             c_reg, carry_q;
    logic             fa_sum, fa_carry;
    logic             accept, last_bit;
    logic             busy, done;

    assign accept   = bus.start_i && (state == ST_IDLE || state == ST_DONE);
    assign last_bit = (state == ST_SHIFT) && (count == LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = accept ? ST_SHIFT : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_SHIFT: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    Full_Adder u_fa (
        .a_i     (a_sh[0]),
        .b_i     (b_sh[0]),
        .c_in    (c_reg),
        .sum_o   (fa_sum),
        .carry_o (fa_carry)
    );

    // Subtraction is a + ~b + 1: B is inverted on load and the +1 enters as carry-in.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_sh    <= '0;
            b_sh    <= '0;
            result  <= '0;
            count   <= '0;
            c_reg   <= 1'b0;
            carry_q <= 1'b0;
        end else if (accept) begin
            a_sh    <= bus.a_i;
            b_sh    <= bus.b_i ^ {WIDTH{bus.sub_i == OP_SUB}};
            c_reg   <= bus.sub_i;
            count   <= '0;
            result  <= '0;
            carry_q <= 1'b0;
        end else if (state == ST_SHIFT) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            result <= {fa_sum, result[WIDTH-1:1]};
            c_reg  <= fa_carry;
            count  <= count + 1'b1;
            if (last_bit) carry_q <= fa_carry;
        end
    end

`ifdef SERIAL_ADD_SUB_OVF_EN
    logic c_msb_in;

    // Carry into the sign bit; differs from the carry out exactly on signed overflow.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)      c_msb_in <= 1'b0;
        else if (accept)   c_msb_in <= 1'b0;
        else if (last_bit) c_msb_in <= c_reg;
    end

    assign bus.overflow_o = c_msb_in ^ carry_q;
`else
    assign bus.overflow_o = 1'b0;
`endif

    assign bus.busy_o   = busy;
    assign bus.done_o   = done;
    assign bus.result_o = result;
    assign bus.carry_o  = carry_q;
    assign state_dbg_o  = state;
endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub: driver tasks push expected results into a
// queue, a negedge monitor pops and compares them whenever done_o is high.
module tb_serial_add_sub;
    import add_sub_pkg::*;

    localparam int WIDTH = 4;
    localparam int EW    = WIDTH + 2;
`ifdef SERIAL_ADD_SUB_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    state_t state_dbg;
    int     cyc   = 0;
    int     n_cmp = 0;
    int     n_err = 0;

    logic [EW-1:0] exp_q[$];
    int            done_q[$];

    serial_add_sub_if #(.WIDTH(WIDTH)) bus ();

    serial_add_sub #(.WIDTH(WIDTH)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .bus         (bus),
        .state_dbg_o (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers / driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller is positioned just after a rising edge; start is seen at the next edge.
    task automatic start_op(input logic sub, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] exp_res, input logic exp_c, input logic exp_v);
        bus.start_i = 1'b1;
        bus.sub_i   = sub;
        bus.a_i     = a;
        bus.b_i     = b;
        exp_q.push_back({exp_res, exp_c, exp_v & OVF_EN});
        @(posedge clk);
        #1;
        done_q.push_back(cyc + WIDTH);
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (bus.done_o !== 1'b1 && n < 30) begin
            tick(1);
            n++;
        end
        n_cmp++;
        if (bus.done_o !== 1'b1) begin
            n_err++;
            $display("FAIL done_timeout: got no done_o in %0d cycles, required done_o=1", n);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (bus.done_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done_o=1 at cycle %0d, required no completion", cyc);
            end else begin
                logic [EW-1:0] e;
                int            dc;
                e  = exp_q.pop_front();
                dc = (done_q.size() > 0) ? done_q.pop_front() : -1;
                check("result_carry_ovf", {26'd0, bus.result_o, bus.carry_o, bus.overflow_o}, {26'd0, e});
                check("done_latency", cyc, dc);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        bus.start_i = 1'b0;
        bus.sub_i   = 1'b0;
        bus.a_i     = '0;
        bus.b_i     = '0;

        tick(2);
        check("rst_busy",   bus.busy_o, 0);
        check("rst_done",   bus.done_o, 0);
        check("rst_result", bus.result_o, 0);
        check("rst_carry",  bus.carry_o, 0);
        check("rst_ovf",    bus.overflow_o, 0);
        check("rst_state",  state_dbg, ST_IDLE);
        rst_n = 1'b1;
        tick(1);

        start_op(OP_ADD, 4'h3, 4'h5, 4'h8, 1'b0, 1'b1);
        wait_done();
        tick(1);
        start_op(OP_SUB, 4'h7, 4'h2, 4'h5, 1'b1, 1'b0);
        wait_done();
        tick(1);
        start_op(OP_SUB, 4'h2, 4'h7, 4'hB, 1'b0, 1'b0);
        wait_done();
        tick(1);

        start_op(OP_ADD, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0);
        n = 0;
        while (bus.busy_o === 1'b1 && n < 20) begin
            n++;
            tick(1);
        end
        check("busy_cycles", n, WIDTH);
        wait_done();
        tick(1);
        check("hold_state",  state_dbg, ST_IDLE);
        check("hold_result", bus.result_o, 4'h0);
        check("hold_carry",  bus.carry_o, 1);

        // Request during SHIFT must be dropped; request during DONE chains directly.
        start_op(OP_ADD, 4'h3, 4'h5, 4'h8, 1'b0, 1'b1);
        tick(1);
        bus.start_i = 1'b1;
        bus.sub_i   = OP_ADD;
        bus.a_i     = 4'h1;
        bus.b_i     = 4'h1;
        tick(1);
        bus.start_i = 1'b0;
        wait_done();
        start_op(OP_SUB, 4'h7, 4'h2, 4'h5, 1'b1, 1'b0);
        check("b2b_busy", bus.busy_o, 1);
        wait_done();
        tick(1);

        // Reset in the middle of an operation aborts it.
        start_op(OP_ADD, 4'h3, 4'h5, 4'h8, 1'b0, 1'b1);
        tick(1);
        rst_n = 1'b0;
        #1;
        check("abort_busy",   bus.busy_o, 0);
        check("abort_done",   bus.done_o, 0);
        check("abort_result", bus.result_o, 0);
        check("abort_carry",  bus.carry_o, 0);
        check("abort_ovf",    bus.overflow_o, 0);
        check("abort_state",  state_dbg, ST_IDLE);
        exp_q.delete();
        done_q.delete();
        tick(1);
        rst_n = 1'b1;
        tick(WIDTH + 3);
        check("post_abort_state", state_dbg, ST_IDLE);

        start_op(OP_ADD, 4'h6, 4'h7, 4'hD, 1'b0, 1'b1);
        wait_done();
        tick(2);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
